// File: rtl/packet_mem.sv
// Byte-addressable big-endian packet buffer: word-wide writes, 1-cycle word/half/byte
// reads at any byte alignment, built from four byte-lane block RAMs.
module packet_mem #(
  parameter int ADDR_WIDTH      = 10,
  parameter int BYTE_ADDR_WIDTH = ADDR_WIDTH + 2,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BYTE_ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]                 sz,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      odata,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      idata,
  input  logic                       wr_en
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [ADDR_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] rd_word_next;
  logic [1:0]            rd_lane;

  assign rd_word      = rd_addr[BYTE_ADDR_WIDTH-1:2];
  assign rd_word_next = rd_word + ADDR_WIDTH'(1);
  assign rd_lane      = rd_addr[1:0];

  logic [7:0] bank_q [4];

  // Lane k holds byte k of each word. Lanes below the starting lane belong to the
  // following word, so an unaligned read touches each bank exactly once.
  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] bank_addr;

    assign bank_addr = (2'(k) < rd_lane) ? rd_word_next : rd_word;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= idata[31-8*k -: 8];
      end
    end

    // Separate read port sees the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        bank_q[k] <= mem[bank_addr];
      end
    end
  end

  logic       rd_valid_q;
  logic [1:0] lane_q;
  logic [1:0] sz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      lane_q     <= 2'b00;
      sz_q       <= 2'b00;
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      lane_q     <= rd_lane;
      sz_q       <= sz;
    end
  end

  logic [7:0] rd_byte [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_byte[i] = bank_q[lane_q + 2'(i)];
    end
  end

  always_comb begin
    odata = '0;
    if (rd_valid_q) begin
      case (sz_q)
        SZ_WORD: odata = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        SZ_HALF: odata = {16'h0, rd_byte[0], rd_byte[1]};
        SZ_BYTE: odata = {24'h0, rd_byte[0]};
        default: odata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_mem.sv
// Directed bench for packet_mem: aligned/unaligned reads, hold, reserved size,
// wrap-around, read-first collision and asynchronous reset.
module tb_packet_mem;

  logic        clk;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [1:0]  sz;
  logic        rd_en;
  logic [31:0] odata;
  logic [9:0]  wr_addr;
  logic [31:0] idata;
  logic        wr_en;

  int pass_cnt;
  int total_cnt;

  packet_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .sz      (sz),
    .rd_en   (rd_en),
    .odata   (odata),
    .wr_addr (wr_addr),
    .idata   (idata),
    .wr_en   (wr_en)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic write_word(input logic [9:0] a, input logic [31:0] d);
    wr_addr = a;
    idata   = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [1:0] s,
                            input logic [31:0] exp);
    rd_addr = a;
    sz      = s;
    rd_en   = 1'b1;
    @(negedge clk);
    rd_en   = 1'b0;
    check(tag, odata, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n   = 1'b0;
    rd_addr = '0;
    sz      = 2'b00;
    rd_en   = 1'b0;
    wr_addr = '0;
    idata   = '0;
    wr_en   = 1'b0;
    #1;
    check("reset_init", odata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    write_word(10'd0, 32'h01234567);
    write_word(10'd1, 32'h89ABCDEF);
    write_word(10'd2, 32'h55555555);

    // consecutive-cycle word reads, aligned and unaligned
    read_check("w_at_0", 12'd0, 2'b00, 32'h01234567);
    read_check("w_at_1", 12'd1, 2'b00, 32'h23456789);
    read_check("w_at_2", 12'd2, 2'b00, 32'h456789AB);
    read_check("b_at_2", 12'd2, 2'b10, 32'h00000045);
    read_check("h_at_3", 12'd3, 2'b01, 32'h00006789);
    read_check("b_at_7", 12'd7, 2'b10, 32'h000000EF);
    read_check("w_at_5", 12'd5, 2'b00, 32'hABCDEF55);
    read_check("h_at_8", 12'd8, 2'b01, 32'h00005555);

    // hold while rd_en low and the address moves
    for (int i = 0; i < 3; i++) begin
      rd_addr = 12'(i * 5 + 1);
      sz      = 2'(i);
      @(negedge clk);
      check("hold", odata, 32'h00005555);
    end

    read_check("sz_reserved", 12'd0, 2'b11, 32'h0);

    // asynchronous reset with nonzero output
    read_check("pre_reset", 12'd0, 2'b00, 32'h01234567);
    rst_n = 1'b0;
    #1;
    check("reset_async", odata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_idle", odata, 32'h0);
    read_check("post_reset_read", 12'd4, 2'b00, 32'h89ABCDEF);

    // wrap-around at the top of the byte space
    write_word(10'd1023, 32'hDEADBEEF);
    write_word(10'd0, 32'h01234567);
    read_check("w_wrap_4094", 12'd4094, 2'b00, 32'hBEEF0123);
    read_check("h_wrap_4095", 12'd4095, 2'b01, 32'h0000EF01);
    read_check("b_at_4095", 12'd4095, 2'b10, 32'h000000EF);

    // same-cycle write and overlapping read returns old bytes
    wr_addr = 10'd1;
    idata   = 32'hCAFEF00D;
    wr_en   = 1'b1;
    read_check("collide_old", 12'd2, 2'b00, 32'h456789AB);
    wr_en   = 1'b0;
    read_check("collide_new", 12'd2, 2'b00, 32'h4567CAFE);
    read_check("h_at_6_new", 12'd6, 2'b01, 32'h0000F00D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
